// File: rtl/fp_mul_booth_seq_if.sv
// Handshake bundle between the FP multiplier front end, the sequential
// Booth significand multiplier and the normalization stage.
interface fp_mul_booth_seq_if #(
   parameter int FRAC_W = 23
);
   logic                  in_valid;
   logic                  in_ready;
   logic [FRAC_W-1:0]     frc_X;
   logic [FRAC_W-1:0]     frc_Y;
   logic                  hid_X;
   logic                  hid_Y;
   logic                  out_valid;
   logic                  out_ready;
   logic [2*FRAC_W+1:0]   frc_Z_full;
   logic                  norm_n;

   // Producer of operands and consumer of the product.
   modport master (
      output in_valid, frc_X, frc_Y, hid_X, hid_Y, out_ready,
      input  in_ready, out_valid, frc_Z_full, norm_n
   );

   // The multiplier itself.
   modport slave (
      input  in_valid, frc_X, frc_Y, hid_X, hid_Y, out_ready,
      output in_ready, out_valid, frc_Z_full, norm_n
   );
endinterface

// File: rtl/fp_mul_booth_seq.sv
// Sequential radix-4 Booth significand multiplier: one Booth digit per
// cycle, full 2M-bit unsigned product plus the normalization flag.
module fp_mul_booth_seq #(
   parameter int FRAC_W = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fp_mul_booth_seq_if.slave    bus
);
   localparam int M      = FRAC_W + 1;      // significand width
   localparam int PW     = 2 * M;           // product width
   localparam int AW     = 2 * M + 2;       // accumulator width (signed)
   localparam int BW     = M + 2;           // zero-extended multiplier width
   localparam int DIGITS = BW / 2;          // Booth digits per operation
   localparam int CNT_W  = $clog2(DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [M-1:0]      r_a;
   logic [BW-1:0]     r_b;
   logic [AW-1:0]     r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_zero;
   logic [PW-1:0]     r_prod;
   logic              r_norm;
   logic              w_in_ready;
   logic              w_out_valid;

   logic [M-1:0]      w_a_in;
   logic [BW-1:0]     w_b_in;
   logic              w_zero_in;
   logic              w_accept;
   logic              w_last;
   logic [BW:0]       w_bext;
   logic [2:0]        w_trip;
   logic [AW-1:0]     w_a_ext;
   logic [AW-1:0]     w_pp;
   logic [AW-1:0]     w_acc_nxt;

   assign w_a_in    = {bus.hid_X, bus.frc_X};
   assign w_b_in    = {2'b00, bus.hid_Y, bus.frc_Y};
   assign w_zero_in = (w_a_in == {M{1'b0}}) || (w_b_in == {BW{1'b0}});
   assign w_accept  = bus.in_valid && (r_state == S_IDLE);
   assign w_last    = (r_cnt == CNT_LAST);

   // B[-1] is an implicit 0 appended below the LSB, so digit i reads bits 2i..2i+2 here.
   assign w_bext    = {r_b, 1'b0};
   assign w_trip    = w_bext[{r_cnt, 1'b0} +: 3];
   assign w_a_ext   = {{(AW-M){1'b0}}, r_a};

   // Booth recoding: select digit * A as a two's-complement partial product.
   always_comb begin
      w_pp = {AW{1'b0}};
      case (w_trip)
         3'b001, 3'b010: w_pp = w_a_ext;
         3'b011:         w_pp = w_a_ext << 1;
         3'b100:         w_pp = -(w_a_ext << 1);
         3'b101, 3'b110: w_pp = -w_a_ext;
         default:        w_pp = {AW{1'b0}};
      endcase
   end

   assign w_acc_nxt = r_acc + (w_pp << {r_cnt, 1'b0});

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; a zero operand spends a single CALC cycle and skips the digit loop.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_CALC;
            else          w_state_nxt = S_IDLE;
         end
         S_CALC: begin
            if (r_zero || w_last) w_state_nxt = S_DONE;
            else                  w_state_nxt = S_CALC;
         end
         S_DONE: begin
            if (bus.out_ready) w_state_nxt = S_IDLE;
            else               w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the registered state only.
   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         S_IDLE:  w_in_ready  = 1'b1;
         S_DONE:  w_out_valid = 1'b1;
         default: begin
            w_in_ready  = 1'b0;
            w_out_valid = 1'b0;
         end
      endcase
   end

   // Operand capture, digit accumulation and result load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a    <= {M{1'b0}};
         r_b    <= {BW{1'b0}};
         r_acc  <= {AW{1'b0}};
         r_cnt  <= {CNT_W{1'b0}};
         r_zero <= 1'b0;
         r_prod <= {PW{1'b0}};
         r_norm <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a    <= w_a_in;
                  r_b    <= w_b_in;
                  r_acc  <= {AW{1'b0}};
                  r_cnt  <= {CNT_W{1'b0}};
                  r_zero <= w_zero_in;
               end
            end
            S_CALC: begin
               if (r_zero) begin
                  r_prod <= {PW{1'b0}};
                  r_norm <= 1'b0;
               end else begin
                  r_acc <= w_acc_nxt;
                  if (w_last) begin
                     // Top digit is non-negative, so acc[AW-1:PW] is zero here.
                     r_prod <= w_acc_nxt[PW-1:0];
                     r_norm <= w_acc_nxt[PW-1];
                  end else begin
                     r_cnt <= r_cnt + CNT_ONE;
                  end
               end
            end
            default: begin
               r_prod <= r_prod;
            end
         endcase
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = w_out_valid;
   assign bus.frc_Z_full = r_prod;
   assign bus.norm_n     = r_norm;
endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Self-checking bench for fp_mul_booth_seq: directed vectors, random
// products against an arithmetic reference, zero shortcut, backpressure,
// mid-operation reset and back-to-back throughput.
module tb_fp_mul_booth_seq;
   localparam int FRAC_W = 23;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   cyc;
   int   acc_cyc;

   fp_mul_booth_seq_if #(.FRAC_W(FRAC_W)) bus ();

   fp_mul_booth_seq #(.FRAC_W(FRAC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain unsigned product of the two significands.
   function automatic logic [47:0] ref_prod(input logic hx, input logic [22:0] fx,
                                            input logic hy, input logic [22:0] fy);
      longint unsigned a, b;
      a = longint'({hx, fx});
      b = longint'({hy, fy});
      return 48'(a * b);
   endfunction

   function automatic int ref_lat(input logic hx, input logic [22:0] fx,
                                  input logic hy, input logic [22:0] fy);
      if ({hx, fx} == 24'd0 || {hy, fy} == 24'd0) return 1;
      return 13;
   endfunction

   // Present operands at a falling edge, let one rising edge accept them.
   task automatic do_accept(input logic hx, input logic [22:0] fx,
                            input logic hy, input logic [22:0] fy);
      bus.hid_X = hx; bus.frc_X = fx;
      bus.hid_Y = hy; bus.frc_Y = fy;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
      bus.in_valid = 1'b0;
   endtask

   // Count rising edges after acceptance until out_valid is seen (bounded).
   task automatic wait_out(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
          bus.frc_Z_full !== 48'd0 || bus.norm_n !== 1'b0) begin
         errors++;
         $display("FAIL reset: rdy=%b vld=%b z=%h n=%b want 1 0 0 0",
                  bus.in_ready, bus.out_valid, bus.frc_Z_full, bus.norm_n);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_directed();
      logic        hx [3];
      logic [22:0] fx [3];
      logic        hy [3];
      logic [22:0] fy [3];
      logic [47:0] want [3];
      logic        wn [3];
      int lat;
      hx[0] = 1'b1; fx[0] = 23'h000000; hy[0] = 1'b1; fy[0] = 23'h000000;
      want[0] = 48'h400000000000; wn[0] = 1'b0;
      hx[1] = 1'b1; fx[1] = 23'h7FFFFF; hy[1] = 1'b1; fy[1] = 23'h7FFFFF;
      want[1] = 48'hFFFFFE000001; wn[1] = 1'b1;
      hx[2] = 1'b0; fx[2] = 23'h2DF854; hy[2] = 1'b1; fy[2] = 23'h000000;
      want[2] = 48'h16FC2A000000; wn[2] = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         do_accept(hx[i], fx[i], hy[i], fy[i]);
         wait_out(lat);
         checks++;
         if (lat !== 13) begin
            errors++;
            $display("FAIL directed%0d_latency: got %0d want 13", i, lat);
         end
         checks++;
         if (bus.frc_Z_full !== want[i] || bus.norm_n !== wn[i]) begin
            errors++;
            $display("FAIL directed%0d_product: got %h/%b want %h/%b",
                     i, bus.frc_Z_full, bus.norm_n, want[i], wn[i]);
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      logic hx, hy;
      logic [22:0] fx, fy;
      logic [47:0] want;
      int lat;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         hx = ($urandom_range(0, 7) != 0);
         hy = ($urandom_range(0, 7) != 0);
         fx = 23'($urandom());
         fy = 23'($urandom());
         want = ref_prod(hx, fx, hy, fy);
         checks++;
         if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL random%0d_ready: got %b want 1", i, bus.in_ready);
         end
         do_accept(hx, fx, hy, fy);
         wait_out(lat);
         checks++;
         if (lat !== ref_lat(hx, fx, hy, fy) || bus.frc_Z_full !== want ||
             bus.norm_n !== want[47]) begin
            errors++;
            $display("FAIL random%0d: got lat=%0d z=%h n=%b want lat=%0d z=%h n=%b",
                     i, lat, bus.frc_Z_full, bus.norm_n,
                     ref_lat(hx, fx, hy, fy), want, want[47]);
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_zero_shortcut();
      int lat;
      int seen;
      bus.out_ready = 1'b0;
      do_accept(1'b0, 23'd0, 1'b1, 23'($urandom()));
      wait_out(lat);
      checks++;
      if (lat !== 1 || bus.frc_Z_full !== 48'd0 || bus.norm_n !== 1'b0) begin
         errors++;
         $display("FAIL zero_result: got lat=%0d z=%h n=%b want lat=1 z=0 n=0",
                  lat, bus.frc_Z_full, bus.norm_n);
      end
      bus.hid_X = 1'b1; bus.frc_X = 23'h123456;
      bus.hid_Y = 1'b1; bus.frc_Y = 23'h654321;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.frc_Z_full !== 48'd0) begin
         errors++;
         $display("FAIL zero_done_ignores_input: rdy=%b vld=%b z=%h want 0 1 0",
                  bus.in_ready, bus.out_valid, bus.frc_Z_full);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_handshake: rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
      end
      seen = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL zero_no_queued_op: got %0d valid cycles want 0", seen);
      end
   endtask

   task automatic test_backpressure();
      logic [22:0] fx, fy;
      logic [47:0] want;
      int lat;
      int bad;
      fx = 23'($urandom());
      fy = 23'($urandom());
      want = ref_prod(1'b1, fx, 1'b1, fy);
      bus.out_ready = 1'b0;
      do_accept(1'b1, fx, 1'b1, fy);
      wait_out(lat);
      checks++;
      if (lat !== 13 || bus.frc_Z_full !== want) begin
         errors++;
         $display("FAIL bp_result: got lat=%0d z=%h want lat=13 z=%h", lat, bus.frc_Z_full, want);
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.out_valid !== 1'b1 || bus.frc_Z_full !== want ||
             bus.norm_n !== want[47] || bus.in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.frc_Z_full !== want) begin
         errors++;
         $display("FAIL bp_release: rdy=%b vld=%b z=%h want 1 0 %h",
                  bus.in_ready, bus.out_valid, bus.frc_Z_full, want);
      end
   endtask

   task automatic test_reset_mid_calc();
      int lat;
      int seen;
      bus.out_ready = 1'b1;
      do_accept(1'b1, 23'h2AAAAA, 1'b1, 23'h555555);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.frc_Z_full !== 48'd0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midcalc_reset: vld=%b z=%h rdy=%b want 0 0 1",
                  bus.out_valid, bus.frc_Z_full, bus.in_ready);
      end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL midcalc_aborted: got %0d valid cycles want 0", seen);
      end
      do_accept(1'b1, 23'd0, 1'b1, 23'd0);
      wait_out(lat);
      checks++;
      if (lat !== 13 || bus.frc_Z_full !== 48'h400000000000) begin
         errors++;
         $display("FAIL midcalc_recover: got lat=%0d z=%h want lat=13 z=400000000000",
                  lat, bus.frc_Z_full);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [22:0] fx, fy;
      logic [47:0] want;
      int lat;
      int prev;
      bus.out_ready = 1'b1;
      prev = -1;
      for (int i = 0; i < 4; i++) begin
         fx = 23'($urandom());
         fy = 23'($urandom());
         want = ref_prod(1'b1, fx, 1'b1, fy);
         do_accept(1'b1, fx, 1'b1, fy);
         if (prev >= 0) begin
            checks++;
            if (acc_cyc - prev !== 15) begin
               errors++;
               $display("FAIL b2b%0d_interval: got %0d want 15", i, acc_cyc - prev);
            end
         end
         prev = acc_cyc;
         wait_out(lat);
         checks++;
         if (bus.frc_Z_full !== want) begin
            errors++;
            $display("FAIL b2b%0d_product: got %h want %h", i, bus.frc_Z_full, want);
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      acc_cyc = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.hid_X = 1'b0; bus.frc_X = 23'd0;
      bus.hid_Y = 1'b0; bus.frc_Y = 23'd0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_random();
      test_zero_shortcut();
      test_backpressure();
      test_reset_mid_calc();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
